pseudo_expander: RTL and testbench



---
 rtl/pseudo_expander_pkg.sv | 51 +++++
 rtl/pseudo_expander_if.sv | 30 +++
 rtl/pseudo_rewrite.sv | 55 +++++
 rtl/pseudo_expander.sv | 125 ++++++++++++
 tb/tb_pseudo_expander.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pseudo_expander_pkg.sv
// pseudo_expander_pkg: shared opcode/funct constants, instruction field positions,
// encoding helpers and the expander FSM state type.
// Ports: none (package).
package pseudo_expander_pkg;

    // Opcodes and funct codes the downstream decoder understands.
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    // R-type funct code reserved for the sgt pseudo.
    localparam logic [5:0] SGT_FUNCT = 6'h2c;

    // Scratch register clobbered by the two-word branch expansions ($at).
    localparam logic [4:0] AT_REG   = 5'd1;
    localparam logic [4:0] ZERO_REG = 5'd0;

    // REGIMM rt selectors for the branch pseudos.
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    // Field LSB positions within a 32-bit word.
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;

    // Default width of the expansion statistics counter.
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef enum logic {
        StIdle,
        StPend2
    } state_e;

    // R-type word with shamt forced to zero.
    function automatic logic [31:0] mk_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] mk_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/pseudo_expander_if.sv
// pseudo_expander_if: fetch-side and decode-side handshake bundle for the expander.
// Ports: none; signals
//   in_valid/in_ready/in_instr/in_pc               fetch -> expander
//   out_valid/out_ready/out_instr/out_pc/out_last/out_expanded   expander -> decode
// Modports: master (fetch + decode side), slave (expander).
interface pseudo_expander_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_last;
    logic        out_expanded;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_last, out_expanded
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_last, out_expanded
    );

endinterface

// File: rtl/pseudo_rewrite.sv
// pseudo_rewrite: purely combinational classifier/rewriter for one fetched word.
// Ports:
//   instr      in  32  fetched word
//   word1      out 32  first (or only) native word
//   word2      out 32  second native word, meaningful only when two_word=1
//   two_word   out 1   word is bltz/bgez and expands to two words
//   is_pseudo  out 1   word is one of the recognised pseudos
module pseudo_rewrite
    import pseudo_expander_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] word1,
    output logic [31:0] word2,
    output logic        two_word,
    output logic        is_pseudo
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    assign op    = instr[OP_LSB +: 6];
    assign rs    = instr[RS_LSB +: 5];
    assign rt    = instr[RT_LSB +: 5];
    assign rd    = instr[RD_LSB +: 5];
    assign funct = instr[FUNCT_LSB +: 6];
    assign imm   = instr[IMM_LSB +: 16];

    always_comb begin
        word1     = instr;
        word2     = '0;
        two_word  = 1'b0;
        is_pseudo = 1'b0;
        if (op == OP_REGIMM && rt == RT_BLTZ) begin
            // rs < 0  <=>  (rs < $0) != 0
            word1     = mk_rtype(rs, ZERO_REG, AT_REG, FUNCT_SLT);
            word2     = mk_itype(OP_BNE, AT_REG, ZERO_REG, imm);
            two_word  = 1'b1;
            is_pseudo = 1'b1;
        end else if (op == OP_REGIMM && rt == RT_BGEZ) begin
            word1     = mk_rtype(rs, ZERO_REG, AT_REG, FUNCT_SLT);
            word2     = mk_itype(OP_BEQ, AT_REG, ZERO_REG, imm);
            two_word  = 1'b1;
            is_pseudo = 1'b1;
        end else if (op == OP_RTYPE && funct == SGT_FUNCT) begin
            // rs > rt  <=>  rt < rs: swap the source fields
            word1     = mk_rtype(rt, rs, rd, FUNCT_SLT);
            is_pseudo = 1'b1;
        end
    end

endmodule

// File: rtl/pseudo_expander.sv
// pseudo_expander: expands bltz/bgez/sgt pseudo-instructions into native slt/beq/bne
// words between fetch and decode; native words pass through untouched. Every emitted
// word carries the pseudo's PC so branch offsets need no adjustment.
// Ports:
//   clk        in  1      clock
//   rst_n      in  1      synchronous active-low reset
//   flush      in  1      synchronous pipeline flush, discards any pending output
//   bus        slave      fetch/decode handshake bundle (pseudo_expander_if)
//   exp_count  out CNT_W  saturating count of accepted pseudo words
module pseudo_expander
    import pseudo_expander_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    pseudo_expander_if.slave bus,
    output logic [CNT_W-1:0] exp_count
);

    logic [31:0] word1;
    logic [31:0] word2;
    logic        two_word;
    logic        is_pseudo;

    pseudo_rewrite u_rewrite (
        .instr     (bus.in_instr),
        .word1     (word1),
        .word2     (word2),
        .two_word  (two_word),
        .is_pseudo (is_pseudo)
    );

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [31:0]      out_pc_q, out_pc_d;
    logic             out_last_q, out_last_d;
    logic             out_expanded_q, out_expanded_d;
    logic [31:0]      word2_q, word2_d;
    logic [CNT_W-1:0] exp_count_q, exp_count_d;

    logic in_ready;
    logic accept;

    // Single output entry: accept only when it is empty or draining this cycle.
    assign in_ready = rst_n && !flush && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_last_d     = out_last_q;
        out_expanded_d = out_expanded_q;
        word2_d        = word2_q;
        exp_count_d    = exp_count_q;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        out_valid_d    = 1'b1;
                        out_instr_d    = word1;
                        out_pc_d       = bus.in_pc;
                        out_last_d     = !two_word;
                        out_expanded_d = is_pseudo;
                        word2_d        = word2;
                        state_d        = two_word ? StPend2 : StIdle;
                    end else if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                StPend2: begin
                    // Second word replaces the first on the same edge it is taken.
                    if (bus.out_ready) begin
                        out_instr_d = word2_q;
                        out_last_d  = 1'b1;
                        state_d     = StIdle;
                    end
                end
            endcase
        end

        if (accept && is_pseudo && exp_count_q != '1) begin
            exp_count_d = exp_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            out_last_q     <= 1'b0;
            out_expanded_q <= 1'b0;
            word2_q        <= '0;
            exp_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_last_q     <= out_last_d;
            out_expanded_q <= out_expanded_d;
            word2_q        <= word2_d;
            exp_count_q    <= exp_count_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_instr    = out_instr_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_expanded = out_expanded_q;
    assign exp_count        = exp_count_q;

endmodule

// File: tb/tb_pseudo_expander.sv
// tb_pseudo_expander: scoreboard bench. The driver issues directed and random words,
// predicts acceptance from a queue-level model and pushes the expected native words;
// a separate monitor compares the presented output against the queue head.
module tb_pseudo_expander;

    localparam int unsigned CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] exp_count;

    pseudo_expander_if bus ();

    pseudo_expander #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .exp_count (exp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        last;
        logic        expd;
    } word_t;

    word_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    model_cnt = 0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: expansion rules written as plain field arithmetic.
    task automatic push_expected(input logic [31:0] w, input logic [31:0] pc);
        logic [31:0] op, rs, rt, rd, funct, imm, slt, br;
        bit          pseudo;
        op     = w >> 26;
        rs     = (w >> 21) & 32'h1f;
        rt     = (w >> 16) & 32'h1f;
        rd     = (w >> 11) & 32'h1f;
        funct  = w & 32'h3f;
        imm    = w & 32'hffff;
        pseudo = 1'b0;
        if (op == 1 && (rt == 0 || rt == 1)) begin
            slt = (rs << 21) | (32'd1 << 11) | 32'h2a;
            br  = (((rt == 0) ? 32'd5 : 32'd4) << 26) | (32'd1 << 21) | imm;
            exp_q.push_back('{slt, pc, 1'b0, 1'b1});
            exp_q.push_back('{br, pc, 1'b1, 1'b1});
            pseudo = 1'b1;
        end else if (op == 0 && funct == 32'h2c) begin
            slt = (rt << 21) | (rs << 16) | (rd << 11) | 32'h2a;
            exp_q.push_back('{slt, pc, 1'b1, 1'b1});
            pseudo = 1'b1;
        end else begin
            exp_q.push_back('{w, pc, 1'b1, 1'b0});
        end
        if (pseudo && model_cnt < SAT) model_cnt++;
    endtask

    // One clock of stimulus. Inputs change on the falling edge; predictions settle at +3.
    task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit rn);
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        rst_n         = rn;
        #1;
        exp_rdy = rn && !fl && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
        if (mon_en) begin
            check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            check("exp_count", 64'(exp_count), 64'(model_cnt));
        end
        acc = v && exp_rdy;
        #2;
        if (!rn) begin
            exp_q.delete();
            model_cnt = 0;
        end else if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            push_expected(instr, pc);
        end
    endtask

    // Monitor: presented word must match the queue head; pop on a real transfer.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
                if (bus.out_valid && exp_q.size() != 0) begin
                    w = exp_q[0];
                    check("out_instr_pc", {bus.out_instr, bus.out_pc}, {w.instr, w.pc});
                    check("out_flags", 64'({bus.out_last, bus.out_expanded}),
                          64'({w.last, w.expd}));
                    if (bus.out_ready && rst_n && !flush) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr_pc"}, {bus.out_instr, bus.out_pc}, 64'd0);
        check({tag, "_flags"}, 64'({bus.out_valid, bus.out_last, bus.out_expanded}), 64'd0);
        check({tag, "_count"}, 64'(exp_count), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] instr;
        int          cls;

        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Passthrough add
        step(1, 32'h012A4020, 32'h40, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        // bltz -> slt + bne, in_ready low while the second word is pending
        step(1, 32'h05000010, 32'h100, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        // bgez under backpressure, then zero-bubble drain
        step(1, 32'h0521FFFC, 32'h200, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        // sgt -> single swapped slt
        step(1, 32'h016C502C, 32'h300, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        // Flush during the pending second word; offered word must be refused
        step(1, 32'h05000010, 32'h400, 1, 0, 1);
        step(1, 32'h012A4020, 32'h404, 1, 1, 1);
        step(1, 32'h012A4020, 32'h408, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        // Reset while pending
        step(1, 32'h0521FFFC, 32'h500, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        // Saturation: 17 back-to-back pseudos
        for (int i = 0; i < 17; i++) step(1, 32'h016C502C, 32'h600 + 32'(i * 4), 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        check("exp_count_sat", 64'(exp_count), 64'(SAT));

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            r   = $urandom;
            cls = int'($urandom_range(0, 4));
            case (cls)
                0:       instr = $urandom;
                1:       instr = {6'h01, r[25:21], 5'd0, r[15:0]};
                2:       instr = {6'h01, r[25:21], 5'd1, r[15:0]};
                3:       instr = {6'h00, r[25:6], 6'h2c};
                default: instr = {6'h01, r[25:21], 5'($urandom_range(2, 31)), r[15:0]};
            endcase
            step(($urandom % 4) != 0, instr, $urandom, ($urandom % 4) != 0,
                 ($urandom % 20) == 0, ($urandom % 100) != 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
